muldiv_unit: RTL
================

# muldiv_unit

Parametrised, multi-cycle RISC-V M-extension execution unit: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU on XLEN-bit operands with exact RISC-V signed, divide-by-zero and overflow semantics. It sits beside the single-cycle integer ALU in the execute stage. The decoder routes M-extension ops here instead of the ALU, and the core stalls on the valid/ready handshake.

## Interface
Parameters:
- `XLEN`, 32: operand and result width; any even value ≥ 8.

Ports:
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: op request.
- `in_ready` out 1: unit can accept a request.
- `op` in 3: RISC-V funct3 encoding.
  - 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU.
  - 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `rs1`, `rs2` in XLEN: operands, sampled at acceptance.
- `flush` in 1: abort any in-flight op.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer takes the result.
- `result` out XLEN: registered result.
- `busy` out 1: state ≠ IDLE.

## Operation
- States are IDLE, CALC and DONE.
  - IDLE→CALC on accept, where accept = `in_valid && in_ready && !flush`.
  - CALC→DONE when the iteration count reaches XLEN, or immediately for special cases.
  - DONE→IDLE on `out_valid && out_ready`.
  - `in_ready` = (state == IDLE); requests are never accepted while busy.
- Operand capture at accept: `op`, signs, and magnitudes of rs1/rs2.
  - Signed: DIV, REM, MULH, plus rs1 of MULHSU. Other operands are unsigned.
- Multiply:
  - Forms the 2·XLEN-bit product of the magnitudes, then conditionally negates it.
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
- Divide:
  - Radix-2 restoring, one quotient bit per cycle, XLEN iterations, on magnitudes.
  - Quotient sign = sign(rs1) XOR sign(rs2). Remainder takes the sign of rs1.
- Special cases resolve at accept and skip iteration:
  - rs2 == 0: quotient = all-ones; remainder = rs1.
  - Signed overflow (rs1 = −2^(XLEN−1), rs2 = −1): quotient = rs1; remainder = 0.
- `result` and `out_valid` hold stable while `out_valid && !out_ready`.
- Flush:
  - In any state, flush forces IDLE on the next edge.
  - `out_valid` drops and no result is delivered.
  - If flush coincides with a request, the request is not accepted.
- Reset (async assert, mid-op included):
  - state = IDLE; `out_valid` = 0; `result` = 0; `busy` = 0; `in_ready` = 1; iteration counter = 0.

## Timing
- Accept edge = cycle 0.
- Iterative divide/multiply: `out_valid` rises at cycle XLEN+1.
- Special-case divide: `out_valid` rises at cycle 1.
- Fast multiply (macro set): `out_valid` rises at cycle 1.
- Result handshake completes on the edge where `out_valid && out_ready`; `in_ready` is high the following cycle.
- Back-to-back throughput: one op per (latency + 1) cycles.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - All multiplies use a single-cycle XLEN×XLEN combinational multiplier.
  - The product is registered at accept; CALC→DONE occurs after one cycle.
- Undefined:
  - Multiplies use an iterative shift-add datapath sharing the divider's counter and accumulator register.
  - Latency is XLEN+1.
- Divide behaviour is identical in both builds.

## Structure
- `muldiv_pkg` holds:
  - the `op` funct3 localparams;
  - the state enum (IDLE/CALC/DONE);
  - the special-case constants (all-ones quotient, most-negative value) as functions of XLEN.
- One sub-module, `muldiv_iter_core`: the shared shift/accumulate datapath with its counter (restoring divide step, shift-add multiply step).
- The top level owns the FSM, sign handling, special cases and handshake.

## Test plan
- DIV 7, −2 → 0xFFFFFFFD; REM 7, −2 → 1; DIVU 7, 2 → 3. Each `out_valid` at cycle 33.
- DIVU 100, 0 → 0xFFFFFFFF; REMU 100, 0 → 100. Each `out_valid` at cycle 1.
- DIV 0x80000000, 0xFFFFFFFF → 0x80000000; REM of the same operands → 0. Each at cycle 1.
- rs1 = rs2 = 0xFFFFFFFF:
  - MUL → 1; MULH → 0; MULHU → 0xFFFFFFFE; MULHSU → 0xFFFFFFFF.
  - Latency is 1 with the macro defined, 33 without.
- Back-pressure:
  - Hold `out_ready` low 5 cycles after `out_valid`: `result` stable, `in_ready` low.
  - Release `out_ready`: next request accepted the following cycle.
- Abort:
  - `flush` at cycle 10 of a DIV: no `out_valid`, `in_ready` = 1 next cycle.
  - `rst_n` pulse mid-CALC: all outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants, FSM state type and helpers for the M-extension
// multiply/divide unit (muldiv_unit and muldiv_iter_core).

package muldiv_pkg;

  // funct3 encodings of the M-extension ops
  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Widest XLEN the constant helpers cover; callers truncate to their XLEN.
  localparam int MAX_XLEN = 128;

  // Quotient returned for a divide by zero: every bit set.
  function automatic logic [MAX_XLEN-1:0] all_ones(input int xlen);
    logic [MAX_XLEN-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_XLEN; i++) begin
      if (i < xlen) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Most negative two's-complement value, -2^(xlen-1).
  function automatic logic [MAX_XLEN-1:0] most_neg(input int xlen);
    logic [MAX_XLEN-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_XLEN; i++) begin
      if (i == xlen - 1) v[i] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic rs1_is_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic rs2_is_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// muldiv_iter_core: shared shift/accumulate datapath with its iteration
// down-counter. One restoring-divide step or one shift-add multiply step per
// enabled cycle, on unsigned magnitudes.
//   divide  : acc = partial remainder, sh = dividend shifting out / quotient shifting in
//   multiply: {acc, sh} = partial product, sh low bits = multiplier shifting out

module muldiv_iter_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            load_div,
  input  logic            load_iter,
  input  logic [XLEN-1:0] acc_init,
  input  logic [XLEN-1:0] sh_init,
  input  logic [XLEN-1:0] opb_init,
  input  logic            step,
  output logic [XLEN-1:0] acc,
  output logic [XLEN-1:0] sh,
  output logic            cnt_zero
);

  localparam int CW = $clog2(XLEN + 1);

  logic [XLEN-1:0] opb;
  logic            is_div;
  logic [CW-1:0]   cnt;

  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   diff;
  logic [XLEN:0]   sum;
  logic [XLEN-1:0] acc_nxt;
  logic [XLEN-1:0] sh_nxt;

  assign cnt_zero = (cnt == '0);

  // One iteration of either the restoring divide or the shift-add multiply
  always_comb begin
    rem_sh  = {acc, sh[XLEN-1]};
    diff    = rem_sh - {1'b0, opb};
    sum     = {1'b0, acc} + (sh[0] ? {1'b0, opb} : {(XLEN+1){1'b0}});
    acc_nxt = acc;
    sh_nxt  = sh;
    if (is_div) begin
      // diff[XLEN] set means the trial subtraction went negative: restore
      if (diff[XLEN]) begin
        acc_nxt = rem_sh[XLEN-1:0];
        sh_nxt  = {sh[XLEN-2:0], 1'b0};
      end else begin
        acc_nxt = diff[XLEN-1:0];
        sh_nxt  = {sh[XLEN-2:0], 1'b1};
      end
    end else begin
      acc_nxt = sum[XLEN:1];
      sh_nxt  = {sum[0], sh[XLEN-1:1]};
    end
  end

  // Datapath registers and iteration down-counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      sh     <= '0;
      opb    <= '0;
      is_div <= 1'b0;
      cnt    <= '0;
    end else if (load) begin
      acc    <= acc_init;
      sh     <= sh_init;
      opb    <= opb_init;
      is_div <= load_div;
      cnt    <= load_iter ? CW'(XLEN) : '0;
    end else if (step && !cnt_zero) begin
      acc <= acc_nxt;
      sh  <= sh_nxt;
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RISC-V M-extension unit (MUL/MULH/MULHSU/MULHU,
// DIV/DIVU/REM/REMU) with valid/ready handshakes and flush.
// Build option MULDIV_FAST_MUL_EN: multiplies use a single-cycle combinational
// multiplier instead of the iterative shift-add datapath.
//
// state   | meaning
// IDLE    | waiting for a request, in_ready high
// CALC    | iterating, or one settle cycle for special cases / fast multiply
// DONE    | result held on result/out_valid until out_ready

module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam logic [XLEN-1:0] ALL_ONES = XLEN'(all_ones(XLEN));
  localparam logic [XLEN-1:0] MOST_NEG = XLEN'(most_neg(XLEN));

  state_t          state;
  logic [2:0]      op_q;
  logic            neg_q;
  logic            neg_r;

  logic            accept;
  logic            sgn_a;
  logic            sgn_b;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            div_zero;
  logic            div_ovf;
  logic            special;

  logic            ld_iter;
  logic [XLEN-1:0] ld_acc;
  logic [XLEN-1:0] ld_sh;

  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] sh;
  logic            cnt_zero;
  logic            step;

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   fin;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] prod_fast;
  assign prod_fast = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
`endif

  assign in_ready = (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);
  assign accept   = in_valid && in_ready && !flush;
  assign step     = (state == ST_CALC) && !flush;

  // Operand signs, magnitudes and the divide special cases seen at accept
  always_comb begin
    sgn_a    = rs1_is_signed(op) && rs1[XLEN-1];
    sgn_b    = rs2_is_signed(op) && rs2[XLEN-1];
    mag_a    = sgn_a ? -rs1 : rs1;
    mag_b    = sgn_b ? -rs2 : rs2;
    div_zero = op[2] && (rs2 == '0);
    div_ovf  = ((op == OP_DIV) || (op == OP_REM)) && (rs1 == MOST_NEG) && (rs2 == ALL_ONES);
    special  = div_zero || div_ovf;
  end

  // Initial datapath contents: special cases and fast products skip iteration
  always_comb begin
    ld_iter = 1'b1;
    ld_acc  = '0;
    ld_sh   = mag_a;
    if (op[2]) begin
      if (div_zero) begin
        ld_iter = 1'b0;
        ld_acc  = rs1;
        ld_sh   = ALL_ONES;
      end else if (div_ovf) begin
        ld_iter = 1'b0;
        ld_acc  = '0;
        ld_sh   = rs1;
      end
    end
`ifdef MULDIV_FAST_MUL_EN
    else begin
      ld_iter         = 1'b0;
      {ld_acc, ld_sh} = prod_fast;
    end
`endif
  end

  muldiv_iter_core #(
    .XLEN (XLEN)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .load_div  (op[2]),
    .load_iter (ld_iter),
    .acc_init  (ld_acc),
    .sh_init   (ld_sh),
    .opb_init  (mag_b),
    .step      (step),
    .acc       (acc),
    .sh        (sh),
    .cnt_zero  (cnt_zero)
  );

  // Sign fix-up and result selection from the finished datapath
  always_comb begin
    prod_fix = neg_q ? -{acc, sh} : {acc, sh};
    quo_fix  = neg_q ? -sh : sh;
    rem_fix  = neg_r ? -acc : acc;
    case (op_q)
      OP_MUL:                       fin = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fin = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fin = quo_fix;
      default:                      fin = rem_fix;
    endcase
  end

  // Control FSM with registered result and out_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      op_q      <= OP_MUL;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
    end else if (flush) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q  <= op;
            // special-case values are loaded already signed
            neg_q <= !special && (sgn_a ^ sgn_b);
            neg_r <= !special && sgn_a;
            state <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (cnt_zero) begin
            result    <= fin;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
